video_out_mod: RTL and testbench

- Transmit-side modulator for the datatape link.
- Accepts 4-bit data symbols over a valid/ready handshake and maps each to one of 12 luma levels. Brackets each packet with begin (190) and end (200) marker levels.
- Emits a BT.656-style 8-bit Cb Y Cr Y word stream with EAV/SAV codes, which feeds the TV encoder. Each symbol is held for 4 luma samples, so the receive side can average 4x oversampled luma.

---
 rtl/video_out_mod_pkg.sv | 57 +++++
 rtl/video_out_mod_if.sv | 24 ++
 rtl/video_out_mod_timing.sv | 93 +++++++++
 rtl/video_out_mod.sv | 144 ++++++++++++++
 tb/tb_video_out_mod.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/video_out_mod_pkg.sv
// Shared definitions for the datatape video modulator: level constants,
// FSM state encoding, the symbol-to-luma map and BT.656 timing-code helpers.
package datatape_pkg;

    localparam logic [7:0] LVL_BEGIN    = 8'd190;
    localparam logic [7:0] LVL_END      = 8'd200;
    localparam logic [7:0] LVL_FILL     = 8'd16;
    localparam logic [7:0] LVL_PRE_A    = 8'd70;
    localparam logic [7:0] LVL_PRE_B    = 8'd180;
    localparam logic [7:0] CHROMA_BLANK = 8'h80;
    localparam logic [7:0] LUMA_BLANK   = 8'h10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_BEGIN,
        ST_DATA,
        ST_END
    } state_e;

    // Returns {legal, level}; illegal codes map to the fill level.
    function automatic logic [8:0] sym_to_level(input logic [3:0] sym);
        logic [8:0] r;
        unique case (sym)
            4'b0000: r = {1'b1, 8'd70};
            4'b0001: r = {1'b1, 8'd80};
            4'b0011: r = {1'b1, 8'd90};
            4'b0111: r = {1'b1, 8'd100};
            4'b1111: r = {1'b1, 8'd110};
            4'b1110: r = {1'b1, 8'd120};
            4'b1100: r = {1'b1, 8'd130};
            4'b1000: r = {1'b1, 8'd140};
            4'b1001: r = {1'b1, 8'd150};
            4'b0110: r = {1'b1, 8'd160};
            4'b1010: r = {1'b1, 8'd170};
            4'b0101: r = {1'b1, 8'd180};
            default: r = {1'b0, LVL_FILL};
        endcase
        return r;
    endfunction

    function automatic logic [7:0] xy_code(input logic f, input logic v, input logic h);
        return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

    // Word k (0..3) of an EAV/SAV sequence FF 00 00 XY, field bit fixed at 0.
    function automatic logic [7:0] timing_code(input logic [1:0] k, input logic v, input logic h);
        logic [7:0] r;
        unique case (k)
            2'd0:    r = 8'hFF;
            2'd3:    r = xy_code(1'b0, v, h);
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/video_out_mod_if.sv
// Symbol handshake and video output bundle of the datatape modulator.
// master = symbol source / video sink, slave = the modulator.
interface video_out_mod_if;

    logic [3:0] sym_in;
    logic       sym_valid;
    logic       sym_last;
    logic       sym_ready;
    logic       sym_err;
    logic [7:0] td_out;
    logic       in_packet;
    logic       frame_start;

    modport master (
        output sym_in, sym_valid, sym_last,
        input  sym_ready, sym_err, td_out, in_packet, frame_start
    );

    modport slave (
        input  sym_in, sym_valid, sym_last,
        output sym_ready, sym_err, td_out, in_packet, frame_start
    );

endinterface

// File: rtl/video_out_mod_timing.sv
// Line/word raster for the modulator: counters, EAV/SAV codes, blanking words,
// and the slot-boundary strobe. All outputs describe the word about to be registered.
module video_out_timing
    import datatape_pkg::*;
#(
    parameter int unsigned ACTIVE_WORDS = 1440,
    parameter int unsigned BLANK_WORDS  = 268,
    parameter int unsigned LINES        = 525,
    parameter int unsigned VBLANK_LINES = 20
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    output logic [7:0] word_o,
    output logic       luma_slot_o,
    output logic       boundary_o,
    output logic       line_start_o,
    output logic       frame_pos_o
);

    localparam int unsigned SAV_POS    = 4 + BLANK_WORDS;
    localparam int unsigned ACT_POS    = SAV_POS + 4;
    localparam int unsigned LINE_WORDS = ACT_POS + ACTIVE_WORDS;
    localparam int unsigned WCNT_W     = $clog2(LINE_WORDS);
    localparam int unsigned LCNT_W     = (LINES > 1) ? $clog2(LINES) : 1;

    localparam logic [WCNT_W-1:0] EAV_END_W = WCNT_W'(4);
    localparam logic [WCNT_W-1:0] SAV_W     = WCNT_W'(SAV_POS);
    localparam logic [WCNT_W-1:0] ACT_W     = WCNT_W'(ACT_POS);
    localparam logic [WCNT_W-1:0] LAST_W    = WCNT_W'(LINE_WORDS - 1);
    localparam logic [LCNT_W-1:0] VB_W      = LCNT_W'(VBLANK_LINES);
    localparam logic [LCNT_W-1:0] LLAST_W   = LCNT_W'(LINES - 1);
    localparam logic [1:0]        SAV_LO    = 2'(SAV_POS);
    localparam logic [2:0]        ACT_LO    = 3'(ACT_POS);

    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [LCNT_W-1:0] line_q, line_d;

    logic       vblank;
    logic       in_eav;
    logic       in_sav;
    logic       in_act;
    logic [1:0] sav_k;
    logic [2:0] act_k;

    assign vblank = (line_q < VB_W);
    assign in_eav = (wcnt_q < EAV_END_W);
    assign in_sav = (wcnt_q >= SAV_W) && (wcnt_q < ACT_W);
    assign in_act = (wcnt_q >= ACT_W);
    assign sav_k  = wcnt_q[1:0] - SAV_LO;
    // Position inside the current 8-word slot; ACTIVE_WORDS is a multiple of 8.
    assign act_k  = wcnt_q[2:0] - ACT_LO;

    always_comb begin
        word_o      = CHROMA_BLANK;
        luma_slot_o = 1'b0;
        if (in_eav) begin
            word_o = timing_code(wcnt_q[1:0], vblank, 1'b1);
        end else if (in_sav) begin
            word_o = timing_code(sav_k, vblank, 1'b0);
        end else if (in_act) begin
            if (act_k[0]) begin
                word_o      = LUMA_BLANK;
                luma_slot_o = ~vblank;
            end
        end else if (wcnt_q[0]) begin
            word_o = LUMA_BLANK;
        end
    end

    assign boundary_o   = in_act && !vblank && (act_k == 3'd0);
    assign line_start_o = (wcnt_q == '0);
    assign frame_pos_o  = (wcnt_q == '0) && (line_q == '0);

    always_comb begin
        wcnt_d = wcnt_q + WCNT_W'(1);
        line_d = line_q;
        if (wcnt_q == LAST_W) begin
            wcnt_d = '0;
            line_d = (line_q == LLAST_W) ? '0 : line_q + LCNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wcnt_q <= '0;
            line_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
            line_q <= line_d;
        end
    end

endmodule

// File: rtl/video_out_mod.sv
// Datatape transmit modulator: packs 4-bit symbols into luma slots of a BT.656 stream.
// Define VIDEO_OUT_PREAMBLE_EN to insert alternating 70/180 training slots before BEGIN.
module video_out_mod
    import datatape_pkg::*;
#(
    parameter int unsigned ACTIVE_WORDS   = 1440,
    parameter int unsigned BLANK_WORDS    = 268,
    parameter int unsigned LINES          = 525,
    parameter int unsigned VBLANK_LINES   = 20,
    parameter int unsigned PREAMBLE_SLOTS = 8
) (
    input  logic              clkin,
    input  logic              rst_n,
    video_out_mod_if.slave    bus
);

    localparam int unsigned   PRE_W    = (PREAMBLE_SLOTS > 1) ? $clog2(PREAMBLE_SLOTS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_SLOTS - 1);

    logic [7:0] t_word;
    logic       t_luma;
    logic       t_boundary;
    logic       t_line_start;
    logic       t_frame_pos;

    video_out_timing #(
        .ACTIVE_WORDS (ACTIVE_WORDS),
        .BLANK_WORDS  (BLANK_WORDS),
        .LINES        (LINES),
        .VBLANK_LINES (VBLANK_LINES)
    ) u_timing (
        .clk_i        (clkin),
        .rst_ni       (rst_n),
        .word_o       (t_word),
        .luma_slot_o  (t_luma),
        .boundary_o   (t_boundary),
        .line_start_o (t_line_start),
        .frame_pos_o  (t_frame_pos)
    );

    state_e           state_q, state_d;
    logic [7:0]       slot_lvl_q, slot_lvl_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic             in_packet_q, in_packet_d;
    logic             slot_end_q, slot_end_d;
    logic             sym_err_q, sym_err_d;
    logic [7:0]       td_q, td_d;
    logic             frame_start_q;

    logic             sym_legal;
    logic [7:0]       sym_lvl;
    logic             sym_ready;

    assign {sym_legal, sym_lvl} = sym_to_level(bus.sym_in);
    assign sym_ready = t_boundary && (state_q == ST_DATA);

    // Odd slot words carry the level latched at the slot boundary.
    assign td_d = t_luma ? slot_lvl_q : t_word;

    always_comb begin
        state_d     = state_q;
        slot_lvl_d  = slot_lvl_q;
        pre_cnt_d   = pre_cnt_q;
        in_packet_d = in_packet_q;
        slot_end_d  = slot_end_q;
        sym_err_d   = 1'b0;
        if (t_boundary) begin
            in_packet_d = (state_q != ST_IDLE);
            slot_end_d  = (state_q == ST_END);
            unique case (state_q)
                ST_IDLE: begin
                    slot_lvl_d = LVL_FILL;
                    if (bus.sym_valid) begin
`ifdef VIDEO_OUT_PREAMBLE_EN
                        state_d   = ST_PREAMBLE;
                        pre_cnt_d = '0;
`else
                        state_d   = ST_BEGIN;
`endif
                    end
                end
                ST_PREAMBLE: begin
                    slot_lvl_d = pre_cnt_q[0] ? LVL_PRE_B : LVL_PRE_A;
                    if (pre_cnt_q == PRE_LAST) begin
                        state_d   = ST_BEGIN;
                        pre_cnt_d = '0;
                    end else begin
                        pre_cnt_d = pre_cnt_q + PRE_W'(1);
                    end
                end
                ST_BEGIN: begin
                    slot_lvl_d = LVL_BEGIN;
                    state_d    = ST_DATA;
                end
                ST_DATA: begin
                    slot_lvl_d = LVL_FILL;
                    if (bus.sym_valid) begin
                        slot_lvl_d = sym_legal ? sym_lvl : LVL_FILL;
                        sym_err_d  = ~sym_legal;
                        if (bus.sym_last) state_d = ST_END;
                    end
                end
                ST_END: begin
                    slot_lvl_d = LVL_END;
                    state_d    = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (t_line_start) begin
            // A packet paused over blanking stays flagged unless its END slot just finished.
            in_packet_d = in_packet_q & ~slot_end_q;
            slot_end_d  = 1'b0;
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            slot_lvl_q    <= LVL_FILL;
            pre_cnt_q     <= '0;
            in_packet_q   <= 1'b0;
            slot_end_q    <= 1'b0;
            sym_err_q     <= 1'b0;
            td_q          <= CHROMA_BLANK;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_lvl_q    <= slot_lvl_d;
            pre_cnt_q     <= pre_cnt_d;
            in_packet_q   <= in_packet_d;
            slot_end_q    <= slot_end_d;
            sym_err_q     <= sym_err_d;
            td_q          <= td_d;
            frame_start_q <= t_frame_pos;
        end
    end

    assign bus.sym_ready   = sym_ready;
    assign bus.sym_err     = sym_err_q;
    assign bus.td_out      = td_q;
    assign bus.in_packet   = in_packet_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_video_out_mod.sv
// Randomized bench for video_out_mod on a shrunken raster, checked every cycle
// against a slot-queue reference model of the datatape line format.
module tb_video_out_mod;

    localparam int A   = 64;
    localparam int B   = 12;
    localparam int NL  = 6;
    localparam int VB  = 2;
    localparam int PRE = 8;
    localparam int TOT = A + B + 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    video_out_mod_if vif();

    video_out_mod #(
        .ACTIVE_WORDS   (A),
        .BLANK_WORDS    (B),
        .LINES          (NL),
        .VBLANK_LINES   (VB),
        .PREAMBLE_SLOTS (PRE)
    ) dut (
        .clkin (clk),
        .rst_n (rst_n),
        .bus   (vif)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    endtask

    logic [3:0] codes [12] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
                               4'b1100, 4'b1000, 4'b1001, 4'b0110, 4'b1010, 4'b0101};
    logic [7:0] lvls  [12] = '{8'd70, 8'd80, 8'd90, 8'd100, 8'd110, 8'd120,
                               8'd130, 8'd140, 8'd150, 8'd160, 8'd170, 8'd180};
    logic [3:0] bad   [4]  = '{4'b0010, 4'b0100, 4'b1011, 4'b1101};

    typedef struct packed {
        logic [3:0] s;
        logic       l;
    } sym_t;
    sym_t src[$];

    // Reference model state: raster position, pending forced slots, packet phase.
    int         m_pos, m_line, m_end_left;
    logic [7:0] m_lvl;
    bit         m_data, m_open, m_ready;
    logic [7:0] pend[$];
    logic [7:0] e_td;
    logic       e_err, e_fs, e_inpkt;

    function automatic int lookup(input logic [3:0] s);
        for (int i = 0; i < 12; i++) if (codes[i] == s) return i;
        return -1;
    endfunction

    function automatic bit is_bnd(input int p, input int ln);
        return (ln >= VB) && (p >= B + 8) && (((p - B - 8) % 8) == 0);
    endfunction

    function automatic logic [7:0] exp_code(input int k, input bit v, input bit h);
        if (k == 0) return 8'hFF;
        if (k == 3) return {1'b1, 1'b0, v, h, v ^ h, h, v, v ^ h};
        return 8'h00;
    endfunction

    function automatic logic [7:0] exp_word(input int p, input int ln, input logic [7:0] lvl);
        bit v;
        int a;
        v = (ln < VB);
        if (p < 4) return exp_code(p, v, 1'b1);
        if (p < 4 + B) return ((p - 4) % 2 == 1) ? 8'h10 : 8'h80;
        if (p < 8 + B) return exp_code(p - 4 - B, v, 1'b0);
        a = p - 8 - B;
        if (a % 2 == 0) return 8'h80;
        return v ? 8'h10 : lvl;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_line = 0; m_end_left = 0;
        m_lvl = 8'd16; m_data = 0; m_open = 0; m_ready = 0;
        pend.delete();
    endtask

    task automatic model_edge(input logic v, input logic [3:0] s, input logic l);
        int idx;
        e_err = 1'b0;
        e_fs  = (m_pos == 0) && (m_line == 0);
        if (is_bnd(m_pos, m_line)) begin
            if (pend.size() > 0) begin
                m_lvl  = pend.pop_front();
                m_open = 1;
                if (m_lvl == 8'd190) m_data = 1;
                if (m_lvl == 8'd200) m_end_left = 8;
            end else if (m_data) begin
                m_lvl = 8'd16;
                if (v) begin
                    idx = lookup(s);
                    if (idx >= 0) m_lvl = lvls[idx];
                    else e_err = 1'b1;
                    void'(src.pop_front());
                    if (l) begin
                        m_data = 0;
                        pend.push_back(8'd200);
                    end
                end
            end else begin
                m_lvl = 8'd16;
                if (v) begin
`ifdef VIDEO_OUT_PREAMBLE_EN
                    for (int k = 0; k < PRE; k++) pend.push_back((k % 2 == 1) ? 8'd180 : 8'd70);
`endif
                    pend.push_back(8'd190);
                end
            end
        end
        e_td    = exp_word(m_pos, m_line, m_lvl);
        e_inpkt = m_open;
        if (m_end_left > 0) begin
            m_end_left--;
            if (m_end_left == 0) m_open = 0;
        end
        m_pos++;
        if (m_pos == TOT) begin
            m_pos  = 0;
            m_line = (m_line == NL - 1) ? 0 : m_line + 1;
        end
        m_ready = is_bnd(m_pos, m_line) && m_data && (pend.size() == 0);
    endtask

    task automatic new_packet();
        int len;
        sym_t e;
        len = $urandom_range(1, 12);
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 99) < 12) e.s = bad[$urandom_range(0, 3)];
            else e.s = codes[$urandom_range(0, 11)];
            e.l = (i == len - 1);
            src.push_back(e);
        end
    endtask

    task automatic drive();
        if (src.size() < 2) new_packet();
        vif.sym_valid = ($urandom_range(0, 99) < 75);
        vif.sym_in    = src[0].s;
        vif.sym_last  = src[0].l;
    endtask

    task automatic step();
        logic       v;
        logic [3:0] s;
        logic       l;
        v = vif.sym_valid;
        s = vif.sym_in;
        l = vif.sym_last;
        @(posedge clk);
        #1;
        model_edge(v, s, l);
        check("td_out", vif.td_out, e_td);
        check("in_packet", vif.in_packet, e_inpkt);
        check("frame_start", vif.frame_start, e_fs);
        check("sym_err", vif.sym_err, e_err);
        drive();
        #1;
        check("sym_ready", vif.sym_ready, m_ready);
    endtask

    initial begin
        bit found;
        rst_n = 1'b0;
        vif.sym_valid = 1'b0;
        vif.sym_in    = 4'd0;
        vif.sym_last  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_td_out", vif.td_out, 8'h80);
        check("rst_sym_ready", vif.sym_ready, 1'b0);
        check("rst_sym_err", vif.sym_err, 1'b0);
        check("rst_in_packet", vif.in_packet, 1'b0);
        check("rst_frame_start", vif.frame_start, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        repeat (3000) step();

        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            step();
            if (m_open && m_end_left == 0) found = 1;
        end
        check("midpkt_reached", found, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_td_out", vif.td_out, 8'h80);
        check("async_rst_in_packet", vif.in_packet, 1'b0);
        check("async_rst_sym_ready", vif.sym_ready, 1'b0);
        vif.sym_valid = 1'b0;
        src.delete();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        repeat (2000) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
